pipeline_sequencer: RTL

- Sequences the 4-stage pipeline (IF→IR1, RF→IR2, EX/MEM→IR3, WB→IR4).
- Drives the PC and IR pipeline-register load enables, NOP-bubble selects and PC source select.
- Detects register RAW hazards between RF and the later stages, flushes wrong-path instructions on a taken branch, and drains then halts the machine on STOP.
- Maintains stall/flush performance counters for the cycle-counter display path.

---
 rtl/pipeline_sequencer_pkg.sv | 59 +++++
 rtl/pipeline_sequencer_hazard_unit.sv | 41 ++++
 rtl/pipeline_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Opcode encodings, sequencer states and register-usage decode shared by the
// pipeline sequencer and its hazard unit.
package pipeline_sequencer_pkg;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_NOP   = 4'b1010;

    // ORI and SHIFT are identified by their low three opcode bits only.
    localparam logic [2:0] OP_ORI_LO   = 3'b111;
    localparam logic [2:0] OP_SHIFT_LO = 3'b011;

    localparam logic [1:0] REG_R1 = 2'd1;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} seq_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } reg_use_t;

    function automatic logic is_ori(input logic [3:0] op);
        return op[2:0] == OP_ORI_LO;
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return op[2:0] == OP_SHIFT_LO;
    endfunction

    function automatic reg_use_t writes_reg(input logic [7:0] instr);
        reg_use_t w;
        w.valid = 1'b0;
        w.idx   = instr[7:6];
        if (is_ori(instr[3:0])) begin
            w.valid = 1'b1;
            w.idx   = REG_R1;
        end else if (is_shift(instr[3:0]) ||
                     instr[3:0] inside {OP_LOAD, OP_ADD, OP_SUB, OP_NAND}) begin
            w.valid = 1'b1;
        end
        return w;
    endfunction

    function automatic logic reads_rx(input logic [3:0] op);
        return is_shift(op) || (op inside {OP_STORE, OP_ADD, OP_SUB, OP_NAND});
    endfunction

    function automatic logic reads_ry(input logic [3:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND};
    endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_unit.sv
// RAW hazard detect: the instruction in IR2 reads a register that the
// instruction in IR3 or IR4 has yet to write back. No forwarding exists.
module pipeline_sequencer_hazard_unit
    import pipeline_sequencer_pkg::*;
(
    input  logic [7:0] ir2_i,
    input  logic [7:0] ir3_i,
    input  logic [7:0] ir4_i,
    output logic       hazard_o
);

    reg_use_t wr3;
    reg_use_t wr4;
    logic     rd_rx;
    logic     rd_ry;
    logic     rd_r1;

    function automatic logic conflicts(
        input reg_use_t   w,
        input logic       use_rx,
        input logic       use_ry,
        input logic       use_r1,
        input logic [1:0] rx,
        input logic [1:0] ry
    );
        return w.valid && ((use_rx && (w.idx == rx)) ||
                           (use_ry && (w.idx == ry)) ||
                           (use_r1 && (w.idx == REG_R1)));
    endfunction

    always_comb begin
        wr3      = writes_reg(ir3_i);
        wr4      = writes_reg(ir4_i);
        rd_rx    = reads_rx(ir2_i[3:0]);
        rd_ry    = reads_ry(ir2_i[3:0]);
        rd_r1    = is_ori(ir2_i[3:0]);
        hazard_o = conflicts(wr3, rd_rx, rd_ry, rd_r1, ir2_i[7:6], ir2_i[5:4]) ||
                   conflicts(wr4, rd_rx, rd_ry, rd_r1, ir2_i[7:6], ir2_i[5:4]);
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Four-stage pipeline sequencer: RUN/DRAIN/HALT control with RAW stalls,
// taken-branch flushes and saturating stall/flush event counters.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       IR1_op,
    input  logic [7:0]       IR2,
    input  logic [7:0]       IR3,
    input  logic [7:0]       IR4,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             PCSel,
    output logic             PC1_Load,
    output logic             PC2_Load,
    output logic             PC3_Load,
    output logic             IR_1_Load,
    output logic             IR_2_Load,
    output logic             IR_3_Load,
    output logic             IR_4_Load,
    output logic             IR_1_Nop,
    output logic             IR_2_Nop,
    output logic             IR_3_Nop,
    output logic             CounterOn,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             active;

    pipeline_sequencer_hazard_unit u_hazard_unit (
        .ir2_i    (IR2),
        .ir3_i    (IR3),
        .ir4_i    (IR4),
        .hazard_o (hazard)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        PCWrite     = 1'b0;
        PCSel       = 1'b0;
        PC1_Load    = 1'b0;
        PC2_Load    = 1'b0;
        PC3_Load    = 1'b0;
        IR_1_Load   = 1'b0;
        IR_2_Load   = 1'b0;
        IR_3_Load   = 1'b0;
        IR_4_Load   = 1'b0;
        IR_1_Nop    = 1'b0;
        IR_2_Nop    = 1'b0;
        IR_3_Nop    = 1'b0;
        CounterOn   = 1'b0;
        active      = reset && (state_q != HALT);

        if (active) begin
            CounterOn = 1'b1;
            if (branch_taken) begin
                // Wrong-path flush wins over any hazard and cancels a pending drain.
                PCWrite   = 1'b1;
                PCSel     = 1'b1;
                PC1_Load  = 1'b1;
                PC2_Load  = 1'b1;
                PC3_Load  = 1'b1;
                IR_1_Load = 1'b1;
                IR_2_Load = 1'b1;
                IR_3_Load = 1'b1;
                IR_4_Load = 1'b1;
                IR_1_Nop  = 1'b1;
                IR_2_Nop  = 1'b1;
                IR_3_Nop  = 1'b1;
                if (~&flush_cnt_q) flush_cnt_d = flush_cnt_q + CNT_W'(1);
                state_d   = RUN;
            end else begin
                if (hazard) begin
                    PC3_Load  = 1'b1;
                    IR_3_Load = 1'b1;
                    IR_3_Nop  = 1'b1;
                    IR_4_Load = 1'b1;
                    if (~&stall_cnt_q) stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end else begin
                    PCWrite   = (state_q == RUN);
                    PC1_Load  = (state_q == RUN);
                    PC2_Load  = 1'b1;
                    PC3_Load  = 1'b1;
                    IR_1_Load = 1'b1;
                    IR_2_Load = 1'b1;
                    IR_3_Load = 1'b1;
                    IR_4_Load = 1'b1;
                    IR_1_Nop  = (state_q == DRAIN);
                end

                case (state_q)
                    RUN:     if (IR1_op == OP_STOP) state_d = DRAIN;
                    DRAIN:   if (IR4[3:0] == OP_STOP) state_d = HALT;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    assign halted      = reset && (state_q == HALT);
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
